hc165_reader: RTL and testbench

//  Host-side controller for a daisy-chain of 74HC165 PISO shift registers.

---
 rtl/hc165_pkg.sv | 20 ++
 rtl/hc165_tick_gen.sv | 35 +++
 rtl/hc165_reader.sv | 138 +++++++++++++
 tb/tb_hc165_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc165_pkg.sv
// Shared state encoding and defaults for the 74HC165 chain reader.
package hc165_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StLoad    = ST_LOAD,
        StShiftLo = ST_SHIFT_LO,
        StShiftHi = ST_SHIFT_HI,
        StDone    = ST_DONE
    } state_e;

    localparam int unsigned DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/hc165_tick_gen.sv
// Phase counter: pulses tick_o on the last cycle of every CLK_DIV-cycle phase.
// restart_i forces the count back to 0 so each new phase starts from a clean count.
module hc165_tick_gen
    import hc165_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hc165_reader.sv
// Host controller for a 74HC165 daisy chain: load, shift DATA_W bits in, publish word.
// Optional QH/QH-bar consistency check enabled by defining HC165_QHBAR_CHECK_EN.
module hc165_reader
    import hc165_pkg::*;
#(
    parameter int unsigned NUM_DEV = 1,
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    localparam int unsigned DATA_W = 8 * NUM_DEV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              shift_load,
    output logic              sclk,
    output logic              clock_in_hibit,
    input  logic              qh
`ifdef HC165_QHBAR_CHECK_EN
    ,
    input  logic              qh_bar,
    output logic              err
`endif
);

    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e            state_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, busy_q, sl_q, sclk_q, inh_q;
    logic              tick, restart;

    // Restart the phase count on every state change, including the untimed ones.
    always_comb begin
        restart = tick;
        if (state_q == StIdle) begin
            restart = start;
        end else if (state_q == StDone) begin
            restart = 1'b1;
        end
    end

    hc165_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .restart_i(restart),
        .tick_o   (tick)
    );

`ifdef HC165_QHBAR_CHECK_EN
    logic err_q;
    assign err = err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            sl_q      <= 1'b1;
            sclk_q    <= 1'b0;
            inh_q     <= 1'b1;
`ifdef HC165_QHBAR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= start;
                    if (start) begin
                        state_q   <= StLoad;
                        sl_q      <= 1'b0;
                        bit_cnt_q <= '0;
`ifdef HC165_QHBAR_CHECK_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    if (tick) begin
                        state_q <= StShiftLo;
                        sl_q    <= 1'b1;
                        inh_q   <= 1'b0;
                    end
                end
                StShiftLo: begin
                    if (tick) begin
                        sr_q <= {sr_q[DATA_W-2:0], qh};
`ifdef HC165_QHBAR_CHECK_EN
                        if (qh_bar == qh) begin
                            err_q <= 1'b1;
                        end
`endif
                        // No rising edge after the final sample: the chain is left untouched.
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= StDone;
                            inh_q   <= 1'b1;
                        end else begin
                            state_q <= StShiftHi;
                            sclk_q  <= 1'b1;
                        end
                    end
                end
                StShiftHi: begin
                    if (tick) begin
                        state_q   <= StShiftLo;
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    data_q  <= sr_q;
                    valid_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy           = busy_q;
    assign data_out       = data_q;
    assign data_valid     = valid_q;
    assign shift_load     = sl_q;
    assign sclk           = sclk_q;
    assign clock_in_hibit = inh_q;

endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader: two DUTs (1 and 2 devices) each reading a behavioural 74HC165 chain.
// Define HC165_QHBAR_CHECK_EN to also exercise the QH-bar consistency check.
module tb_hc165_reader;

    localparam int CD1  = 4;
    localparam int CD2  = 3;
    localparam int LAT1 = 2 * CD1 * 8 + 1;
    localparam int LAT2 = 2 * CD2 * 16 + 1;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;

    logic        start1 = 1'b0, busy1, valid1, sl1, sclk1, inh1, qh1;
    logic [7:0]  dout1, par1 = '0, ch1 = '0;
    logic        start2 = 1'b0, busy2, valid2, sl2, sclk2, inh2, qh2;
    logic [15:0] dout2, par2 = '0, ch2 = '0;
    int          edges1 = 0, low1 = 0, edges2 = 0, low2 = 0;

`ifdef HC165_QHBAR_CHECK_EN
    logic qhb1, qhb2, err1, err2;
    bit   bad_en = 1'b0;
    int   bad_base = 0;
    int   bad_bit = 0;
    assign qhb1 = ~qh1 ^ (bad_en && ((edges1 - bad_base) == bad_bit));
    assign qhb2 = ~qh2;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural chains: SH/LD low loads the parallel word, CLK rising edge shifts toward QH.
    always @(posedge sclk1 or negedge sl1) begin
        if (!sl1) ch1 <= par1;
        else if (!inh1) ch1 <= {ch1[6:0], 1'b0};
    end
    always @(posedge sclk2 or negedge sl2) begin
        if (!sl2) ch2 <= par2;
        else if (!inh2) ch2 <= {ch2[14:0], 1'b0};
    end
    assign qh1 = ch1[7];
    assign qh2 = ch2[15];

    always @(posedge sclk1) edges1 <= edges1 + 1;
    always @(posedge sclk2) edges2 <= edges2 + 1;
    always @(posedge clk) if (!sl1) low1 <= low1 + 1;
    always @(posedge clk) if (!sl2) low2 <= low2 + 1;

    hc165_reader #(
        .NUM_DEV(1),
        .CLK_DIV(CD1)
    ) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .start         (start1),
        .busy          (busy1),
        .data_out      (dout1),
        .data_valid    (valid1),
        .shift_load    (sl1),
        .sclk          (sclk1),
        .clock_in_hibit(inh1),
        .qh            (qh1)
`ifdef HC165_QHBAR_CHECK_EN
        ,
        .qh_bar        (qhb1),
        .err           (err1)
`endif
    );

    hc165_reader #(
        .NUM_DEV(2),
        .CLK_DIV(CD2)
    ) u_dut2 (
        .clk           (clk),
        .reset         (reset),
        .start         (start2),
        .busy          (busy2),
        .data_out      (dout2),
        .data_valid    (valid2),
        .shift_load    (sl2),
        .sclk          (sclk2),
        .clock_in_hibit(inh2),
        .qh            (qh2)
`ifdef HC165_QHBAR_CHECK_EN
        ,
        .qh_bar        (qhb2),
        .err           (err2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_valid1(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (valid1) seen = 1'b1;
        end
        check({tag, " valid seen"}, 32'(seen), 32'd1);
    endtask

    // One scan on the single-device DUT; expected word is simply the loaded parallel value.
    task automatic scan1(input logic [7:0] v, input bit poke, input string tag);
        int t0, e0, l0;
        par1 = v;
        e0 = edges1;
        l0 = low1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        t0 = cyc;
        check({tag, " busy"}, 32'(busy1), 32'd1);
        if (poke) begin
            repeat (20) @(negedge clk);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
        wait_valid1(tag);
        check({tag, " latency"}, 32'(cyc - t0), 32'(LAT1));
        check({tag, " data"}, 32'(dout1), 32'(v));
        check({tag, " sclk edges"}, 32'(edges1 - e0), 32'd7);
        check({tag, " load cycles"}, 32'(low1 - l0), 32'(CD1));
        @(negedge clk);
        check({tag, " busy drop"}, 32'(busy1), 32'd0);
    endtask

    task automatic scan2(input logic [15:0] v, input string tag);
        int t0, e0, l0;
        bit seen = 1'b0;
        par2 = v;
        e0 = edges2;
        l0 = low2;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (valid2) seen = 1'b1;
        end
        check({tag, " valid seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc - t0), 32'(LAT2));
        check({tag, " data"}, 32'(dout2), 32'(v));
        check({tag, " sclk edges"}, 32'(edges2 - e0), 32'd15);
        check({tag, " load cycles"}, 32'(low2 - l0), 32'(CD2));
    endtask

    initial begin
        logic [7:0] vals[3];
        int tv[3];
        logic [7:0] last;
        bit ok;
        int e0;
        bit reached;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst shift_load", 32'(sl1), 32'd1);
        check("rst sclk", 32'(sclk1), 32'd0);
        check("rst clk_inh", 32'(inh1), 32'd1);
        check("rst busy", 32'(busy1), 32'd0);
        check("rst valid", 32'(valid1), 32'd0);
        check("rst data", 32'(dout1), 32'd0);
`ifdef HC165_QHBAR_CHECK_EN
        check("rst err", 32'(err1), 32'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        scan1(8'hAA, 1'b1, "aa");

        // A start pulse during the scan must not queue a second scan.
        last = dout1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (sclk1 !== 1'b0 || sl1 !== 1'b1 || dout1 !== last || valid1 !== 1'b0 ||
                busy1 !== 1'b0) ok = 1'b0;
        end
        check("idle hold", 32'(ok), 32'd1);

        for (int i = 0; i < 4; i++) scan1(8'($urandom), 1'b0, $sformatf("rnd1_%0d", i));

        scan2(16'hCC0F, "cc0f");
        for (int i = 0; i < 2; i++) scan2(16'($urandom), $sformatf("rnd2_%0d", i));

        vals[0] = 8'h01;
        vals[1] = 8'h80;
        vals[2] = 8'hFF;
        par1 = vals[0];
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid1($sformatf("b2b_%0d", k));
            tv[k] = cyc;
            check($sformatf("b2b_%0d data", k), 32'(dout1), 32'(vals[k]));
            if (k < 2) par1 = vals[k + 1];
            else start1 = 1'b0;
        end
        check("b2b gap0", 32'(tv[1] - tv[0]), 32'(LAT1 + 1));
        check("b2b gap1", 32'(tv[2] - tv[1]), 32'(LAT1 + 1));
        @(negedge clk);
        check("b2b busy drop", 32'(busy1), 32'd0);

        // Reset in the middle of shifting, after bit 3 has been taken.
        par1 = 8'($urandom);
        e0 = edges1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (edges1 - e0 >= 4) reached = 1'b1;
        end
        check("mid reach", 32'(reached), 32'd1);
        reset = 1'b1;
        #1;
        check("mid shift_load", 32'(sl1), 32'd1);
        check("mid sclk", 32'(sclk1), 32'd0);
        check("mid clk_inh", 32'(inh1), 32'd1);
        check("mid busy", 32'(busy1), 32'd0);
        check("mid data", 32'(dout1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        scan1(8'($urandom), 1'b0, "post_rst");

`ifdef HC165_QHBAR_CHECK_EN
        check("err clean", 32'(err1), 32'd0);
        bad_base = edges1;
        bad_bit = 5;
        bad_en = 1'b1;
        scan1(8'h5C, 1'b0, "qhbar");
        bad_en = 1'b0;
        check("err set", 32'(err1), 32'd1);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("err clear", 32'(err1), 32'd0);
        wait_valid1("err_after");
        check("err stays", 32'(err1), 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
